// File: rtl/rcswitch_cmd_filter.sv
// Debounces decoded rcswitch frames into single-cycle switch commands with a per-channel state register.
// Optional macro RCSWITCH_REJECT_STATS_EN builds a saturating rejected-frame counter.
module rcswitch_cmd_filter #(
  parameter logic [39:0] MY_ADDR     = 40'h8888888888,
  parameter int          REPEAT      = 2,
  parameter int          GAP_TIMEOUT = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [39:0] addr,
  input  logic [39:0] chan,
  input  logic [15:0] stat,
  output logic        cmd_valid,
  output logic [1:0]  cmd_chan,
  output logic        cmd_on,
  output logic [3:0]  state,
  output logic [7:0]  reject_count
);

  typedef enum logic [1:0] {IDLE, CHECK, COUNT, HOLD} fsm_t;

  fsm_t        r_fsm, w_fsm_nxt, r_prior;
  logic        r_ready_q;
  logic        w_rise;
  logic [39:0] r_addr_p0, r_chan_p0;
  logic [15:0] r_stat_p0;
  logic [2:0]  r_cand;
  logic        r_cand_vld;
  logic [3:0]  r_count;
  logic [15:0] r_timer;

  logic        w_in_check, w_waiting, w_valid, w_on, w_match, w_timeout;
  logic [1:0]  w_chan_id;
  logic [2:0]  w_frame;
  logic [3:0]  w_count_nxt;
  logic        w_reject, w_hold_rep, w_fire;

  function automatic logic chan_ok(input logic [39:0] c);
    int   zeros;
    logic ok;
    ok    = (c[7:0] == 8'h8E);
    zeros = 0;
    for (int i = 1; i < 5; i++) begin
      if (c[i*8 +: 8] == 8'h88)      zeros++;
      else if (c[i*8 +: 8] != 8'h8E) ok = 1'b0;
    end
    return ok && (zeros == 1);
  endfunction

  // The '0' byte marks the channel; the most significant data byte is channel A.
  function automatic logic [1:0] chan_idx(input logic [39:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 1; i < 5; i++)
      if (c[i*8 +: 8] == 8'h88) idx = 2'(4 - i);
    return idx;
  endfunction

  assign w_rise = ready & ~r_ready_q;

  // Stage p0: edge detect and frame capture
  always_ff @(posedge clk) begin
    if (!rst) r_ready_q <= 1'b0;
    else      r_ready_q <= ready;
  end

  always_ff @(posedge clk) begin
    if (w_rise && (r_fsm != CHECK)) begin
      r_addr_p0 <= addr;
      r_chan_p0 <= chan;
      r_stat_p0 <= stat;
    end
  end

  // Stage p1: decode and validate the captured frame
  assign w_in_check  = (r_fsm == CHECK);
  assign w_waiting   = (r_fsm == COUNT) || (r_fsm == HOLD);
  assign w_valid     = (r_addr_p0 == MY_ADDR) && chan_ok(r_chan_p0) &&
                       ((r_stat_p0 == 16'h888E) || (r_stat_p0 == 16'h8E88));
  assign w_on        = (r_stat_p0 == 16'h888E);
  assign w_chan_id   = chan_idx(r_chan_p0);
  assign w_frame     = {w_chan_id, w_on};
  assign w_match     = r_cand_vld && (r_cand == w_frame);
  assign w_count_nxt = w_match ? (r_count + 4'd1) : 4'd1;
  assign w_timeout   = w_waiting && !w_rise && (r_timer == 16'(GAP_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm   <= IDLE;
      r_prior <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm != CHECK) r_prior <= r_fsm;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_rise) w_fsm_nxt = CHECK;
      CHECK: begin
        if (w_reject)                 w_fsm_nxt = r_prior;
        else if (w_hold_rep || w_fire) w_fsm_nxt = HOLD;
        else                          w_fsm_nxt = COUNT;
      end
      default: begin
        if (w_rise)         w_fsm_nxt = CHECK;
        else if (w_timeout) w_fsm_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_reject   = 1'b0;
    w_hold_rep = 1'b0;
    w_fire     = 1'b0;
    if (w_in_check) begin
      w_reject   = !w_valid;
      w_hold_rep = w_valid && (r_prior == HOLD) && w_match;
      w_fire     = w_valid && !w_hold_rep && (w_count_nxt >= 4'(REPEAT));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cand     <= 3'd0;
      r_cand_vld <= 1'b0;
      r_count    <= 4'd0;
      r_timer    <= 16'd0;
    end else begin
      if (w_timeout) begin
        r_cand     <= 3'd0;
        r_cand_vld <= 1'b0;
        r_count    <= 4'd0;
      end else if (w_in_check && w_valid && !w_hold_rep) begin
        r_cand     <= w_frame;
        r_cand_vld <= 1'b1;
        r_count    <= w_count_nxt;
      end
      if ((w_in_check && w_valid) || w_timeout) r_timer <= 16'd0;
      else if (w_waiting && !w_rise)            r_timer <= r_timer + 16'd1;
    end
  end

  // Stage p2: registered command outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_valid <= 1'b0;
      cmd_chan  <= 2'd0;
      cmd_on    <= 1'b0;
      state     <= 4'h0;
    end else begin
      cmd_valid <= w_fire;
      if (w_fire) begin
        cmd_chan         <= w_chan_id;
        cmd_on           <= w_on;
        state[w_chan_id] <= w_on;
      end
    end
  end

`ifdef RCSWITCH_REJECT_STATS_EN
  logic [7:0] r_reject_cnt;
  always_ff @(posedge clk) begin
    if (!rst)                               r_reject_cnt <= 8'h00;
    else if (w_reject && r_reject_cnt != 8'hFF) r_reject_cnt <= r_reject_cnt + 8'd1;
  end
  assign reject_count = r_reject_cnt;
`else
  assign reject_count = 8'h00;
`endif

endmodule

// File: tb/tb_rcswitch_cmd_filter.sv
// Bench for rcswitch_cmd_filter: frame table plus reset and saturation sequences, scoreboarded commands.
module tb_rcswitch_cmd_filter;

  localparam logic [39:0] ADDR_OK = 40'h8888888888;
  localparam logic [39:0] CH_A = 40'h888E8E8E8E;
  localparam logic [39:0] CH_B = 40'h8E888E8E8E;
  localparam logic [39:0] CH_C = 40'h8E8E888E8E;
  localparam logic [39:0] CH_D = 40'h8E8E8E888E;
  localparam logic [15:0] S_ON  = 16'h888E;
  localparam logic [15:0] S_OFF = 16'h8E88;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0;
  logic [39:0] addr = '0, chan = '0;
  logic [15:0] stat = '0;
  logic        cmd_valid, cmd_on;
  logic [1:0]  cmd_chan;
  logic [3:0]  state;
  logic [7:0]  reject_count;

  rcswitch_cmd_filter dut (
    .clk(clk), .rst(rst), .ready(ready), .addr(addr), .chan(chan), .stat(stat),
    .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_on(cmd_on), .state(state),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
    logic       on;
    logic [3:0] st;
  } exp_t;

  typedef struct {
    logic [39:0] a;
    logic [39:0] c;
    logic [15:0] s;
    logic        fire;
    logic [1:0]  ch;
    logic        on;
    int          gap;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_state = 4'h0;
  logic       prev_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Command monitor: every cmd_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && cmd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {30'd0, cmd_chan}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cmd_cycle", cyc, e.cyc);
        check("cmd_chan", {30'd0, cmd_chan}, {30'd0, e.ch});
        check("cmd_on", {31'd0, cmd_on}, {31'd0, e.on});
        check("cmd_state", {28'd0, state}, {28'd0, e.st});
      end
      check("cmd_no_back_to_back", {31'd0, prev_vld}, 32'd0);
    end
    prev_vld = cmd_valid;
  end

  task automatic send(input logic [39:0] a, input logic [39:0] c, input logic [15:0] s,
                      input logic fire, input logic [1:0] ch, input logic on, input int gap);
    exp_t e;
    @(negedge clk);
    addr  = a;
    chan  = c;
    stat  = s;
    ready = 1'b1;
    if (fire) begin
      exp_state[ch] = on;
      e.cyc = cyc + 2;
      e.ch  = ch;
      e.on  = on;
      e.st  = exp_state;
      exp_q.push_back(e);
    end
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_cmd_chan"}, {30'd0, cmd_chan}, 32'd0);
    check({tag, "_cmd_on"}, {31'd0, cmd_on}, 32'd0);
    check({tag, "_state"}, {28'd0, state}, 32'd0);
    check({tag, "_reject_count"}, {24'd0, reject_count}, 32'd0);
  endtask

  initial begin
    logic [7:0] sat_exp;
`ifdef RCSWITCH_REJECT_STATS_EN
    sat_exp = 8'hFF;
`else
    sat_exp = 8'h00;
`endif

    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 50});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b1, 2'd1, 1'b1, 50});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 50});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 50});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 1300});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 50});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b1, 2'd1, 1'b1, 50});
    vecs.push_back('{40'h888888888E, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 20});
    vecs.push_back('{ADDR_OK, 40'h888E888E8E, S_ON, 1'b0, 2'd0, 1'b0, 20});
    vecs.push_back('{ADDR_OK, CH_B, 16'h8888, 1'b0, 2'd0, 1'b0, 20});
    vecs.push_back('{ADDR_OK, CH_A, S_ON, 1'b0, 2'd0, 1'b0, 30});
    vecs.push_back('{ADDR_OK, CH_B, S_ON, 1'b0, 2'd0, 1'b0, 30});
    vecs.push_back('{ADDR_OK, CH_A, S_ON, 1'b0, 2'd0, 1'b0, 30});
    vecs.push_back('{ADDR_OK, CH_A, S_ON, 1'b1, 2'd0, 1'b1, 30});
    vecs.push_back('{ADDR_OK, CH_A, S_ON, 1'b0, 2'd0, 1'b0, 30});
    vecs.push_back('{ADDR_OK, CH_C, S_ON, 1'b0, 2'd0, 1'b0, 30});
    vecs.push_back('{ADDR_OK, CH_C, S_ON, 1'b1, 2'd2, 1'b1, 30});
    vecs.push_back('{ADDR_OK, CH_D, S_OFF, 1'b0, 2'd0, 1'b0, 30});
    vecs.push_back('{ADDR_OK, CH_D, S_OFF, 1'b1, 2'd3, 1'b0, 30});

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].a, vecs[i].c, vecs[i].s, vecs[i].fire, vecs[i].ch, vecs[i].on, vecs[i].gap);

    check("state_after_table", {28'd0, state}, 32'h7);
    check("last_cmd_chan", {30'd0, cmd_chan}, 32'd3);
    check("last_cmd_on", {31'd0, cmd_on}, 32'd0);
    check("reject_count_3", {24'd0, reject_count}, {24'd0, (sat_exp == 8'hFF) ? 8'd3 : 8'd0});
    check("missed_cmds_table", exp_q.size(), 32'd0);

    // Reset lands on the CHECK cycle of the frame that would fire.
    send(ADDR_OK, CH_B, S_OFF, 1'b0, 2'd0, 1'b0, 30);
    @(negedge clk);
    addr  = ADDR_OK;
    chan  = CH_B;
    stat  = S_OFF;
    ready = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_state = 4'h0;
    repeat (4) @(negedge clk);
    check_idle_outputs("mid_check_reset");

    for (int i = 0; i < 260; i++)
      send(ADDR_OK, CH_A, 16'h8888, 1'b0, 2'd0, 1'b0, 1);
    check("reject_sat", {24'd0, reject_count}, {24'd0, sat_exp});
    repeat (300) @(negedge clk);
    check("reject_sat_hold", {24'd0, reject_count}, {24'd0, sat_exp});
    send(ADDR_OK, CH_A, 16'h8888, 1'b0, 2'd0, 1'b0, 5);
    check("reject_sat_extra", {24'd0, reject_count}, {24'd0, sat_exp});
    check("state_after_rejects", {28'd0, state}, 32'd0);

    repeat (5) @(negedge clk);
    check("missed_cmds_final", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcswitch_cmd_filter.md
Name: rcswitch_cmd_filter

Overview:
- Sits directly downstream of the rcswitch receiver and consumes its decoded frame fields (addr, chan, stat) plus its ready strobe.
- Validates the tri-state symbol encoding and matches the frame against a configured address.
- Requires REPEAT consecutive identical frames, then emits one clean single-cycle command (channel, on/off).
- Suppresses the remote's repeated transmissions until the air goes quiet, and keeps a 4-bit output state register for the LED/relay logic.

Parameters:
MY_ADDR, 40'h8888888888, address field a frame must equal to be accepted
REPEAT, 2, consecutive identical valid frames required before a command is emitted (legal range 1..15)
GAP_TIMEOUT, 1200, clk cycles of no new frame after which the candidate/hold is dropped (16-bit counter)

Ports:
clk  input  1  block clock (divided rcswitch clock domain)
rst  input  1  synchronous reset, active-low
ready  input  1  receiver frame-ready level; a new frame is indicated by its 0->1 transition
addr  input  40  received address symbols, stable while ready=1
chan  input  40  received channel symbols, stable while ready=1
stat  input  16  received state symbols, stable while ready=1
cmd_valid  output  1  single-cycle pulse: new command accepted
cmd_chan  output  2  channel of the command (0=A..3=D), valid with cmd_valid, held afterwards
cmd_on  output  1  1=ON, 0=OFF, valid with cmd_valid, held afterwards
state  output  4  per-channel switch state, updated on cmd_valid
reject_count  output  8  rejected-frame counter (see Optional Feature)

Behaviour:
- Reset is synchronous and active-low: rst is sampled on posedge clk and takes effect when rst=0. Reset values:
  - cmd_valid=0, cmd_chan=0, cmd_on=0, state=4'h0, reject_count=0.
  - Internal: ready_q=0, match count=0, timeout counter=0, FSM=IDLE.
- Edge detect: ready_q registers ready each cycle. rise = ready & ~ready_q.
  - The frame fields are captured into internal registers on the rise cycle (cycle n).
- Symbol decode (cycle n+1), byte-wise: 8'h88 = '0', 8'h8E = 'F'; any other byte makes the frame invalid.
- Frame valid only if all of the following hold:
  - addr == MY_ADDR.
  - chan bytes [39:8]: exactly one byte is 8'h88 and the rest are 8'h8E; chan[7:0] == 8'h8E.
    - Position of the 8'h88 byte: [39:32]->0, [31:24]->1, [23:16]->2, [15:8]->3.
  - stat == 16'h888E (ON) or 16'h8E88 (OFF).
- FSM states: IDLE, CHECK, COUNT, HOLD.
  - IDLE: on rise -> CHECK.
  - CHECK (one cycle):
    - Invalid frame: reject and return to the prior state (IDLE or COUNT or HOLD). Candidate and counter are unchanged.
    - Valid frame equal to the stored candidate {chan_id, on}: count++.
    - Valid frame not equal to the candidate: the candidate becomes this frame and count=1.
    - If count reaches REPEAT: cmd_valid=1 on the cycle after CHECK (n+2), cmd_chan/cmd_on updated, state[chan_id]=on, -> HOLD.
    - Otherwise -> COUNT.
    - With REPEAT=1 the first valid frame fires at n+2.
  - COUNT: waiting for further frames; on rise -> CHECK.
  - HOLD: frames equal to the emitted command refresh the timeout and emit nothing. A different valid frame restarts counting: candidate=frame, count=1, -> COUNT (or fire immediately if REPEAT=1).
- Timeout: the counter clears on every valid frame and increments each cycle in COUNT/HOLD. When it reaches GAP_TIMEOUT: -> IDLE, candidate cleared, count=0. state and cmd_* are unaffected.
- A rise coinciding with the timeout expiry cycle: the rise wins. The frame is processed; the timeout is ignored that cycle.
- A rise arriving while in CHECK cannot occur (ready must toggle through 0). If ready is held high, no further frames are seen.
- Reset mid-frame (rst=0 while in CHECK): all state is cleared and no cmd_valid is emitted.
- cmd_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: RCSWITCH_REJECT_STATS_EN.
- Defined: reject_count increments by 1 on each CHECK that rejects a frame, saturating at 8'hFF. It clears only on reset.
- Undefined: reject_count is tied to 8'h00 and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset then two valid frames (chan=40'h8E888E8E8E, stat=16'h888E, REPEAT=2), rises 50 cycles apart -> one cmd_valid pulse exactly 2 cycles after the second rise; cmd_chan=1, cmd_on=1, state=4'b0010.
- After the above, three further identical frames within GAP_TIMEOUT -> no cmd_valid. Idle for more than 1200 cycles, then two identical frames -> a second cmd_valid.
- Frame with addr=40'h888888888E, then a frame with chan=40'h888E888E8E (two zeros), then stat=16'h8888 -> no cmd_valid; with RCSWITCH_REJECT_STATS_EN, reject_count=3.
- Alternating frames A-ON then B-ON then A-ON -> no command (count restarts each time). Then A-ON twice more -> cmd_chan=0, cmd_on=1.
- In HOLD after C-ON, send D-OFF twice -> cmd_chan=3, cmd_on=0; state shows bit2=1 and bit3=0.
- rst=0 for one cycle on the CHECK cycle of the REPEAT-th frame -> no cmd_valid, all outputs 0. 300 cycles of reject_count at 8'hFF saturation (forced 260 rejects) -> holds at 8'hFF.
